// File: rtl/bnn_io_sequencer.sv
// Byte-stream sequencer driving the tiny_bnn io_in bus (slow clock, setup, parameter shift, nibble banks).
// Optional parameter-bit counting with param_done is enabled by defining BNN_PARAM_COUNT_EN.
module bnn_io_sequencer #(
    parameter int PARAM_BYTES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_is_param,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] io_in_o,
    input  logic [7:0] io_out_i,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic       param_done
);

    typedef enum logic [2:0] {
        IDLE, P_LO, P_HI, X_LO_L, X_LO_H, X_HI_L, X_HI_H, CAPTURE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] io_in_q, io_in_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_valid_q, res_valid_d;
    logic       accept_s;
    logic       drop_s;

    if (PARAM_BYTES < 1) begin : g_param_check
        $error("PARAM_BYTES must be at least 1");
    end

    assign s_ready  = (state_q == IDLE) & ~reset;
    assign accept_s = s_valid & s_ready;

`ifdef BNN_PARAM_COUNT_EN
    localparam int TOTAL_BITS = PARAM_BYTES * 8;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Count each completed parameter bit (the end of every P_HI slot).
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (state_q == P_HI) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        done_d = (cnt_d == CNT_W'(TOTAL_BITS));
    end

    // Parameter bit counter and completion flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign drop_s     = done_q;
    assign param_done = done_q;
`else
    assign drop_s     = 1'b0;
    assign param_done = 1'b0;
`endif

    // Sequencing FSM; io_in is computed from the next state so the bus is registered.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        bit_d       = bit_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        io_in_d     = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    byte_d = s_data;
                    bit_d  = 3'd7;
                    if (!s_is_param) begin
                        state_d = X_LO_L;
                    end else if (!drop_s) begin
                        state_d = P_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            P_LO: state_d = P_HI;
            P_HI: begin
                if (bit_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = P_LO;
                    bit_d   = bit_q - 3'd1;
                end
            end
            X_LO_L: state_d = X_LO_H;
            X_LO_H: state_d = X_HI_L;
            X_HI_L: state_d = X_HI_H;
            X_HI_H: state_d = CAPTURE;
            CAPTURE: begin
                state_d     = IDLE;
                res_data_d  = io_out_i;
                res_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Bus layout: {x_nibble[3:0], x_bank_hi, param_in, setup, bnn_clk}
        case (state_d)
            P_LO:    io_in_d = {4'h0, 1'b0, byte_d[bit_d], 1'b1, 1'b0};
            P_HI:    io_in_d = {4'h0, 1'b0, byte_d[bit_d], 1'b1, 1'b1};
            X_LO_L:  io_in_d = {byte_d[3:0], 1'b0, 2'b00, 1'b0};
            X_LO_H:  io_in_d = {byte_d[3:0], 1'b0, 2'b00, 1'b1};
            X_HI_L:  io_in_d = {byte_d[7:4], 1'b1, 2'b00, 1'b0};
            X_HI_H:  io_in_d = {byte_d[7:4], 1'b1, 2'b00, 1'b1};
            default: io_in_d = 8'h00;
        endcase
    end

    // State and output registers; reset aborts any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_q      <= 8'h00;
            bit_q       <= 3'd0;
            io_in_q     <= 8'h00;
            res_data_q  <= 8'h00;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
            io_in_q     <= io_in_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign io_in_o   = io_in_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_bnn_io_sequencer.sv
// Self-checking bench for bnn_io_sequencer: transaction-level schedule model plus directed literal pins.
module tb_bnn_io_sequencer;

    localparam int PB = 2;
`ifdef BNN_PARAM_COUNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_is_param = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] io_in_o;
    logic [7:0] io_out_i = 8'h00;
    logic [7:0] res_data;
    logic       res_valid;
    logic       param_done;

    bnn_io_sequencer #(.PARAM_BYTES(PB)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_is_param(s_is_param),
        .s_valid(s_valid), .s_ready(s_ready), .io_in_o(io_in_o), .io_out_i(io_out_i),
        .res_data(res_data), .res_valid(res_valid), .param_done(param_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: list of io_in values the bus must show on upcoming cycles.
    typedef struct {
        logic [7:0] io;
        bit         cap;
        bit         last;
    } ent_t;

    ent_t       sched[$];
    logic [7:0] exp_io = 8'h00;
    bit         cur_busy = 1'b0;
    bit         cur_cap = 1'b0;
    bit         cur_last = 1'b0;
    logic       exp_rv = 1'b0;
    logic [7:0] exp_rd = 8'h00;
    int         bytes_done = 0;
    logic       exp_done = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] io, input bit cap, input bit last);
        ent_t e;
        e.io = io; e.cap = cap; e.last = last;
        sched.push_back(e);
    endtask

    task automatic advance(input logic r, input logic v, input logic [7:0] d, input logic p,
                           input logic [7:0] o);
        ent_t e;
        if (r) begin
            sched.delete();
            exp_io = 8'h00; cur_busy = 1'b0; cur_cap = 1'b0; cur_last = 1'b0;
            exp_rv = 1'b0; exp_rd = 8'h00; bytes_done = 0; exp_done = 1'b0;
        end else begin
            if (!cur_busy && v) begin
                if (!p) begin
                    push({d[3:0], 1'b0, 3'b000}, 1'b0, 1'b0);
                    push({d[3:0], 1'b0, 3'b001}, 1'b0, 1'b0);
                    push({d[7:4], 1'b1, 3'b000}, 1'b0, 1'b0);
                    push({d[7:4], 1'b1, 3'b001}, 1'b0, 1'b0);
                    push(8'h00, 1'b1, 1'b0);
                end else if (!(FEAT && exp_done)) begin
                    for (int j = 0; j < 16; j++) begin
                        logic b;
                        b = d[7 - j / 2];
                        push({5'b00000, b, 1'b1, (j % 2 == 1)}, 1'b0, (j == 15));
                    end
                end
            end
            exp_rv = cur_cap;
            if (cur_cap) exp_rd = o;
            if (cur_last) bytes_done++;
            exp_done = FEAT && (bytes_done >= PB);
            if (sched.size() > 0) begin
                e = sched.pop_front();
                exp_io = e.io; cur_busy = 1'b1; cur_cap = e.cap; cur_last = e.last;
            end else begin
                exp_io = 8'h00; cur_busy = 1'b0; cur_cap = 1'b0; cur_last = 1'b0;
            end
        end
    endtask

    // One cycle: drive inputs on the falling edge, compare against the model, then advance it.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic p,
                        input logic [7:0] o);
        @(negedge clk);
        reset = r; s_valid = v; s_data = d; s_is_param = p; io_out_i = o;
        #1;
        chk("s_ready", s_ready, !cur_busy && !r);
        chk("io_in_o", io_in_o, exp_io);
        chk("res_valid", res_valid, exp_rv);
        chk("res_data", res_data, exp_rd);
        chk("param_done", param_done, exp_done);
        advance(r, v, d, p, o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    logic [7:0] x_lit [5];
    logic       a5_bits [8];

    initial begin
        x_lit[0] = 8'hC0; x_lit[1] = 8'hC1; x_lit[2] = 8'h38; x_lit[3] = 8'h39; x_lit[4] = 8'h00;
        a5_bits[0] = 1'b1; a5_bits[1] = 1'b0; a5_bits[2] = 1'b1; a5_bits[3] = 1'b0;
        a5_bits[4] = 1'b0; a5_bits[5] = 1'b1; a5_bits[6] = 1'b0; a5_bits[7] = 1'b1;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00);
        chk("rst_s_ready", s_ready, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rel_s_ready", s_ready, 8'h01);
        chk("rel_io", io_in_o, 8'h00);
        chk("rel_res_valid", res_valid, 8'h00);
        chk("rel_param_done", param_done, 8'h00);

        // Input byte 3C with io_out 5A
        step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h5A);
            chk("x_io_lit", io_in_o, x_lit[k]);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h11);
        chk("x_res_data", res_data, 8'h5A);
        chk("x_res_valid", res_valid, 8'h01);
        chk("x_ready_t6", s_ready, 8'h01);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h22);
        chk("x_res_valid_t7", res_valid, 8'h00);
        chk("x_res_hold", res_data, 8'h5A);

        // Param byte A5
        step(1'b0, 1'b1, 8'hA5, 1'b1, 8'h00);
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
            chk("p_param_in", io_in_o[2], a5_bits[j / 2]);
            chk("p_setup", io_in_o[1], 8'h01);
            chk("p_bnn_clk", io_in_o[0], (j % 2 == 1));
            if (j == 15) chk("p_ready_t16", s_ready, 8'h00);
        end
        s_valid = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("p_ready_t17", s_ready, 8'h01);

        // Second parameter byte completes the PB=2 load; third one is dropped or shifted
        step(1'b0, 1'b1, 8'h0F, 1'b1, 8'h00);
        idle(17);
        chk("p_done_2", param_done, FEAT);
        step(1'b0, 1'b1, 8'hFF, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("p3_io", io_in_o, FEAT ? 8'h00 : 8'h06);
        chk("p3_ready", s_ready, FEAT);
        idle(17);

        // Reset during t+3 of an input byte
        step(1'b0, 1'b1, 8'h96, 1'b0, 8'h77);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h77);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h77);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h77);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h77);
        chk("abort_io", io_in_o, 8'h00);
        chk("abort_ready", s_ready, 8'h01);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h77);
            chk("abort_no_res", res_valid, 8'h00);
        end

        // s_valid held high with alternating tags
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'b1, 8'($urandom), (i / 7) % 2 == 1, 8'($urandom));
        end

        // Randomized traffic with occasional resets and valid bursts
        for (int i = 0; i < 4000; i++) begin
            logic r, v;
            r = ($urandom_range(0, 249) == 0);
            v = ((i / 64) % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step(r, v, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
